// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and its datapath/memories.
// The sequencer side uses the master modport; the environment uses slave.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             run;
  logic [1:0]       op;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             busy;
  logic             fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, op, imem_ack, dmem_ack,
    output imem_req, dmem_req, ir_write, pc_write, pc_src, alu_op,
           reg_write, mem_read, mem_write, busy, fault, state, instr_count
  );

  modport slave (
    output run, op, imem_ack, dmem_ack,
    input  imem_req, dmem_req, ir_write, pc_write, pc_src, alu_op,
           reg_write, mem_read, mem_write, busy, fault, state, instr_count
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB controller for the 2-bit-opcode core, with
// req/ack memory handshakes and a sticky FAULT trap on ack timeout.
module multicycle_sequencer_chk (
  input logic clk,
  input logic reset,
  input logic reg_write,
  input logic mem_read,
  input logic mem_write,
  input logic ir_write,
  input logic imem_ack
);
  a_one_strobe: assert property (@(posedge clk) disable iff (reset)
    $onehot0({reg_write, mem_read, mem_write}));

  a_ir_needs_ack: assert property (@(posedge clk) disable iff (reset)
    ir_write |-> imem_ack);
endmodule

module multicycle_sequencer #(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  // Wait counter only has to reach ACK_TIMEOUT-1; the next miss traps.
  localparam int WAIT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               retire_s;
  logic               waiting_s;
  logic               ack_s;
  logic               timeout_s;

  assign timeout_s = (ACK_TIMEOUT != 0) && (wait_q == WAIT_LAST);

  // State, latched opcode, wait counter and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      wait_q  <= {WAIT_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, retire and counter logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retire_s  = 1'b0;
    waiting_s = 1'b0;
    ack_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
        else         state_d = S_IDLE;
      end
      S_FETCH: begin
        waiting_s = 1'b1;
        ack_s     = bus.imem_ack;
        if (bus.imem_ack) state_d = S_DECODE;
        else if (timeout_s) state_d = S_FAULT;
        else state_d = S_FETCH;
      end
      S_DECODE: begin
        op_d    = bus.op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:           state_d = S_WB;
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default: begin
            retire_s = 1'b1;
            state_d  = bus.run ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        waiting_s = 1'b1;
        ack_s     = bus.dmem_ack;
        if (bus.dmem_ack) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            retire_s = 1'b1;
            state_d  = bus.run ? S_FETCH : S_IDLE;
          end
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        retire_s = 1'b1;
        state_d  = bus.run ? S_FETCH : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    if (waiting_s && !ack_s && (ACK_TIMEOUT != 0)) wait_d = wait_q + WAIT_W'(1'b1);
    else                                          wait_d = {WAIT_W{1'b0}};

    if (retire_s) cnt_d = cnt_q + CNT_W'(1'b1);
    else          cnt_d = cnt_q;
  end

  // Strobes decoded from state, latched opcode and the live acks.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.alu_op    = 2'b00;
    bus.reg_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ack;
        bus.pc_write = bus.imem_ack;
      end
      S_EXEC: begin
        bus.pc_write = (op_q == OP_JUMP);
        bus.pc_src   = (op_q == OP_JUMP);
      end
      S_MEM: begin
        bus.dmem_req  = 1'b1;
        bus.mem_read  = (op_q == OP_LOAD);
        bus.mem_write = (op_q == OP_STORE);
      end
      S_WB:    bus.reg_write = 1'b1;
      default: bus.alu_op    = 2'b00;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.fault       = (state_q == S_FAULT);
  assign bus.state       = state_q;
  assign bus.instr_count = cnt_q;

  multicycle_sequencer_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .reg_write (bus.reg_write),
    .mem_read  (bus.mem_read),
    .mem_write (bus.mem_write),
    .ir_write  (bus.ir_write),
    .imem_ack  (bus.imem_ack)
  );
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: vector table, hand-built corner sequences
// and random stimulus against a stage-list reference model.
module tb_multicycle_sequencer;
  localparam int CNT_W = 4;
  localparam int TO    = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(.ACK_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: current stage number plus list of stages still to visit.
  int         m_st;
  logic [1:0] m_op;
  int         m_cnt;
  int         m_wait;
  int         plan[$];

  typedef struct {
    logic       run;
    logic [1:0] op;
    logic       ia;
    logic       da;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [7:0] fl;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_op = 2'b00; m_cnt = 0; m_wait = 0;
    plan.delete();
  endtask

  task automatic m_advance(input logic r);
    if (plan.size() == 0) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_st  = r ? 1 : 0;
    end else begin
      m_st = plan.pop_front();
    end
    m_wait = 0;
  endtask

  task automatic m_edge(input logic r, input logic [1:0] o, input logic ia, input logic da);
    case (m_st)
      0: if (r) begin m_st = 1; m_wait = 0; end
      1: begin
        if (ia) begin m_st = 2; m_wait = 0; end
        else begin m_wait++; if (m_wait == TO) m_st = 6; end
      end
      2: begin
        m_op = o;
        plan.delete();
        if (o == 2'b00) plan.push_back(5);
        else if (o == 2'b01) begin plan.push_back(4); plan.push_back(5); end
        else if (o == 2'b10) plan.push_back(4);
        m_st = 3;
      end
      3, 5: m_advance(r);
      4: begin
        if (da) m_advance(r);
        else begin m_wait++; if (m_wait == TO) m_st = 6; end
      end
      default: m_st = m_st;
    endcase
  endtask

  function automatic logic [18:0] m_out(input logic ia);
    logic ireq, dreq, irw, pcw, pcs, rw, mr, mw;
    ireq = (m_st == 1);
    dreq = (m_st == 4);
    irw  = ireq && ia;
    pcs  = (m_st == 3) && (m_op == 2'b11);
    pcw  = irw || pcs;
    rw   = (m_st == 5);
    mr   = dreq && (m_op == 2'b01);
    mw   = dreq && (m_op == 2'b10);
    return {ireq, dreq, irw, pcw, pcs, 2'b00, rw, mr, mw, (m_st != 0), (m_st == 6),
            3'(m_st), 4'(m_cnt)};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op,
            bus.reg_write, bus.mem_read, bus.mem_write, bus.busy, bus.fault, bus.state,
            bus.instr_count};
  endfunction

  function automatic logic [7:0] dut_flags();
    return {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.pc_src,
            bus.reg_write, bus.mem_read, bus.mem_write};
  endfunction

  task automatic drive(input logic r, input logic [1:0] o, input logic ia, input logic da);
    @(negedge clk);
    bus.run = r; bus.op = o; bus.imem_ack = ia; bus.dmem_ack = da;
    #1;
    check("model", 32'(dut_vec()), 32'(m_out(ia)));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge(bus.run, bus.op, bus.imem_ack, bus.dmem_ack);
  endtask

  task automatic cycle(input logic r, input logic [1:0] o, input logic ia, input logic da);
    drive(r, o, ia, da);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b0; bus.op = 2'b00; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    m_reset();
    #1;
    check("reset_out", 32'(dut_vec()), 32'(m_out(1'b0)));
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int rd, wb, wb_k, flt, req;
    bus.run = 1'b0; bus.op = 2'b00; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    m_reset();

    tbl[0]  = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd0, 4'd0, 8'h00};
    tbl[1]  = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd1, 4'd0, 8'hB0};
    tbl[2]  = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd2, 4'd0, 8'h00};
    tbl[3]  = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd3, 4'd0, 8'h00};
    tbl[4]  = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd5, 4'd0, 8'h04};
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 1'b1, 3'd1, 4'd1, 8'hB0};
    tbl[6]  = '{1'b1, 2'b01, 1'b1, 1'b1, 3'd2, 4'd1, 8'h00};
    tbl[7]  = '{1'b1, 2'b01, 1'b1, 1'b1, 3'd3, 4'd1, 8'h00};
    tbl[8]  = '{1'b1, 2'b01, 1'b1, 1'b1, 3'd4, 4'd1, 8'h42};
    tbl[9]  = '{1'b1, 2'b01, 1'b1, 1'b1, 3'd5, 4'd1, 8'h04};
    tbl[10] = '{1'b1, 2'b10, 1'b1, 1'b1, 3'd1, 4'd2, 8'hB0};
    tbl[11] = '{1'b1, 2'b10, 1'b1, 1'b1, 3'd2, 4'd2, 8'h00};
    tbl[12] = '{1'b1, 2'b10, 1'b1, 1'b1, 3'd3, 4'd2, 8'h00};
    tbl[13] = '{1'b1, 2'b10, 1'b1, 1'b1, 3'd4, 4'd2, 8'h41};
    tbl[14] = '{1'b1, 2'b11, 1'b1, 1'b1, 3'd1, 4'd3, 8'hB0};
    tbl[15] = '{1'b1, 2'b11, 1'b1, 1'b1, 3'd2, 4'd3, 8'h00};
    tbl[16] = '{1'b1, 2'b11, 1'b1, 1'b1, 3'd3, 4'd3, 8'h18};
    tbl[17] = '{1'b1, 2'b00, 1'b1, 1'b1, 3'd1, 4'd4, 8'hB0};

    // Program ADD, LOAD, STORE, JUMP with both acks tied high.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].run, tbl[i].op, tbl[i].ia, tbl[i].da);
      check($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_count", i), 32'(bus.instr_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_flags", i), 32'(dut_flags()), 32'(tbl[i].fl));
      tick();
    end

    // LOAD with dmem_ack three cycles late.
    do_reset();
    rd = 0; wb = 0; wb_k = -1; flt = 0;
    for (int k = 0; k < 12; k++) begin
      drive((k == 0), 2'b01, 1'b1, (k >= 7));
      if (bus.mem_read && bus.dmem_req) rd++;
      if (bus.reg_write) begin wb++; if (wb_k < 0) wb_k = k; end
      if (bus.fault) flt++;
      tick();
    end
    check("load_read_cycles", 32'(rd), 32'd4);
    check("load_wb_cycles", 32'(wb), 32'd1);
    check("load_wb_when", 32'(wb_k), 32'd8);
    check("load_fault", 32'(flt), 32'd0);

    // imem_ack never arrives: trap after 15 request cycles.
    do_reset();
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    req = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b0);
      if (bus.imem_req) req++;
      tick();
    end
    check("to_req_cycles", 32'(req), 32'd15);
    for (int k = 0; k < 6; k++) cycle(k[0], 2'b01, 1'b1, 1'b1);
    drive(1'b1, 2'b00, 1'b1, 1'b1);
    check("to_state", 32'(bus.state), 32'd6);
    check("to_fault", 32'(bus.fault), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd1);
    check("to_flags", 32'(dut_flags()), 32'd0);
    check("to_count", 32'(bus.instr_count), 32'd0);
    tick();

    // Ack in the 15th request cycle is still accepted.
    do_reset();
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) cycle(1'b1, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 1'b1, 1'b0);
    check("late_ack_irw", 32'(bus.ir_write), 32'd1);
    tick();
    drive(1'b1, 2'b00, 1'b1, 1'b0);
    check("late_ack_state", 32'(bus.state), 32'd2);
    check("late_ack_fault", 32'(bus.fault), 32'd0);
    tick();

    // dmem_ack never arrives in MEM of a STORE.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'b10, 1'b1, 1'b0);
    req = 0;
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, 2'b10, 1'b1, 1'b0);
      if (bus.dmem_req) req++;
      tick();
    end
    check("dto_req_cycles", 32'(req), 32'd15);
    check("dto_state", 32'(bus.state), 32'd6);

    // run dropped during MEM of a STORE.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'b10, 1'b1, 1'b0);
    cycle(1'b0, 2'b10, 1'b1, 1'b0);
    cycle(1'b0, 2'b10, 1'b1, 1'b0);
    drive(1'b0, 2'b10, 1'b1, 1'b1);
    check("st_mem_write", 32'(bus.mem_write), 32'd1);
    tick();
    drive(1'b0, 2'b10, 1'b1, 1'b1);
    check("st_state", 32'(bus.state), 32'd0);
    check("st_busy", 32'(bus.busy), 32'd0);
    check("st_count", 32'(bus.instr_count), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'b00, 1'b1, 1'b1);

    // Async reset in the middle of a LOAD's MEM wait.
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0);
    check("ar_pre_dreq", 32'(bus.dmem_req), 32'd1);
    check("ar_pre_count", 32'(bus.instr_count), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("ar_state", 32'(bus.state), 32'd0);
    check("ar_dreq", 32'(bus.dmem_req), 32'd0);
    check("ar_mread", 32'(bus.mem_read), 32'd0);
    check("ar_count", 32'(bus.instr_count), 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0; bus.run = 1'b0;
    tick();

    // Sixteen JUMPs wrap the 4-bit counter.
    do_reset();
    cycle(1'b1, 2'b11, 1'b1, 1'b1);
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 2'b11, 1'b1, 1'b1);
      check($sformatf("wrap_count%0d", j), 32'(bus.instr_count), 32'(j));
      tick();
      cycle(1'b1, 2'b11, 1'b1, 1'b1);
      cycle(1'b1, 2'b11, 1'b1, 1'b1);
    end
    drive(1'b0, 2'b11, 1'b0, 1'b0);
    check("wrap_zero", 32'(bus.instr_count), 32'd0);
    check("wrap_state", 32'(bus.state), 32'd1);
    check("wrap_fault", 32'(bus.fault), 32'd0);
    tick();

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((n % 700) == 699) do_reset();
      cycle(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
